// File: rtl/id_pkg.sv
// Shared definitions for the instruction-decode stage.
// - Instruction field bit positions
// - Opcode constants
// - Load / store / rt-consumer classification
// - Immediate-extension selection
package id_pkg;

    // Instruction field bit positions
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_MSB  = 10;
    localparam int SHAMT_LSB  = 6;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;

    // Opcode constants
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    // How the 16-bit immediate is widened to the datapath
    typedef enum logic [1:0] {
        EXT_SIGN  = 2'd0,
        EXT_ZERO  = 2'd1,
        EXT_UPPER = 2'd2
    } imm_ext_e;

    // Loads occupy the whole 6'b100xxx opcode group
    function automatic logic is_load(input logic [5:0] opcode);
        return opcode[5:3] == 3'b100;
    endfunction

    // Stores occupy the whole 6'b101xxx opcode group
    function automatic logic is_store(input logic [5:0] opcode);
        return opcode[5:3] == 3'b101;
    endfunction

    // Instructions that read rt as a source operand
    function automatic logic is_rt_consumer(input logic [5:0] opcode);
        return (opcode == OP_RTYPE) || is_store(opcode) ||
               (opcode == OP_BEQ)   || (opcode == OP_BNE);
    endfunction

    // Logical immediates are unsigned, LUI loads the upper half,
    // everything else is sign-extended.
    function automatic imm_ext_e imm_ext_kind(input logic [5:0] opcode);
        imm_ext_e kind;
        case (opcode)
            OP_ANDI, OP_ORI, OP_XORI: kind = EXT_ZERO;
            OP_LUI:                   kind = EXT_UPPER;
            default:                  kind = EXT_SIGN;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/id_regfile_bypass.sv
// Register file with two combinational read ports and one write port.
// Register 0 always reads zero; writes to 0 or to out-of-range
// addresses are dropped. A write in the same cycle as a read of the
// same nonzero address is forwarded to the read port.
// Ports:
//   clk, srst               clock, synchronous active-high reset (clears all)
//   wr_en/wr_addr/wr_data   write port (takes effect at rising edge)
//   rd_addr_a/rd_data_a     read port A
//   rd_addr_b/rd_data_b     read port B
module id_regfile_bypass #(
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5,
    parameter int N_REGS  = 32
) (
    input  logic               clk,
    input  logic               srst,
    input  logic               wr_en,
    input  logic [NB_REG-1:0]  wr_addr,
    input  logic [NB_DATA-1:0] wr_data,
    input  logic [NB_REG-1:0]  rd_addr_a,
    input  logic [NB_REG-1:0]  rd_addr_b,
    output logic [NB_DATA-1:0] rd_data_a,
    output logic [NB_DATA-1:0] rd_data_b
);

    // One extra bit so N_REGS == 2**NB_REG stays representable
    localparam logic [NB_REG:0] REG_COUNT = (NB_REG + 1)'(N_REGS);

    logic [NB_DATA-1:0] regs_reg [N_REGS];
    logic               wr_ok;

    assign wr_ok = wr_en && (wr_addr != '0) && ({1'b0, wr_addr} < REG_COUNT);

    always_ff @(posedge clk) begin
        if (srst) begin
            for (int i = 0; i < N_REGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (wr_ok) begin
            regs_reg[wr_addr] <= wr_data;
        end
    end

    logic [NB_REG-1:0]  rd_addr [2];
    logic [NB_DATA-1:0] rd_data [2];

    assign rd_addr[0] = rd_addr_a;
    assign rd_addr[1] = rd_addr_b;
    assign rd_data_a  = rd_data[0];
    assign rd_data_b  = rd_data[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_read_port
            always_comb begin
                rd_data[gi] = '0;
                if (rd_addr[gi] != '0) begin
                    if (wr_en && (wr_addr == rd_addr[gi])) begin
                        rd_data[gi] = wr_data;
                    end else if ({1'b0, rd_addr[gi]} < REG_COUNT) begin
                        rd_data[gi] = regs_reg[rd_addr[gi]];
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/id_pipeline.sv
// Instruction-decode stage: field decode, register read with write-back
// bypass, immediate extension, load-use hazard detection and the ID/EX
// pipeline register.
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_valid, i_pc,
//   i_instruction         IF/ID contents
//   i_flush               squash the instruction currently in ID
//   i_wb_write/addr/data  write-back port into the register file
//   o_stall               combinational load-use stall request to IF
//   o_valid .. o_funct    registered ID/EX entry
module id_pipeline
    import id_pkg::*;
#(
    parameter int NB_DATA  = 32,
    parameter int NB_INST  = 32,
    parameter int NB_REG   = 5,
    parameter int N_REGS   = 32,
    parameter int NB_IMMED = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_valid,
    input  logic [NB_DATA-1:0] i_pc,
    input  logic [NB_INST-1:0] i_instruction,
    input  logic               i_flush,
    input  logic               i_wb_write,
    input  logic [NB_REG-1:0]  i_wb_addr,
    input  logic [NB_DATA-1:0] i_wb_data,
    output logic               o_stall,
    output logic               o_valid,
    output logic [NB_DATA-1:0] o_pc,
    output logic [NB_DATA-1:0] o_data_1,
    output logic [NB_DATA-1:0] o_data_2,
    output logic [NB_DATA-1:0] o_imm,
    output logic [NB_REG-1:0]  o_rs,
    output logic [NB_REG-1:0]  o_rt,
    output logic [NB_REG-1:0]  o_rd,
    output logic [5:0]         o_opcode,
    output logic [5:0]         o_funct
);

    // ---------------- field decode ----------------
    logic [5:0]          opcode;
    logic [NB_REG-1:0]   rs;
    logic [NB_REG-1:0]   rt;
    logic [NB_REG-1:0]   rd;
    logic [5:0]          funct;
    logic [NB_IMMED-1:0] imm;
    logic                unused_shamt;

    assign opcode = i_instruction[OPCODE_MSB:OPCODE_LSB];
    assign rs     = i_instruction[RS_MSB:RS_LSB];
    assign rt     = i_instruction[RT_MSB:RT_LSB];
    assign rd     = i_instruction[RD_MSB:RD_LSB];
    assign funct  = i_instruction[FUNCT_MSB:FUNCT_LSB];
    assign imm    = i_instruction[NB_IMMED-1:0];
    assign unused_shamt = ^i_instruction[SHAMT_MSB:SHAMT_LSB];

    // ---------------- immediate extension ----------------
    logic [NB_DATA-1:0] imm_ext;

    always_comb begin
        case (imm_ext_kind(opcode))
            EXT_ZERO:  imm_ext = {{(NB_DATA-NB_IMMED){1'b0}}, imm};
            EXT_UPPER: imm_ext = {imm, {(NB_DATA-NB_IMMED){1'b0}}};
            default:   imm_ext = {{(NB_DATA-NB_IMMED){imm[NB_IMMED-1]}}, imm};
        endcase
    end

    // ---------------- register file ----------------
    logic [NB_DATA-1:0] rs_data;
    logic [NB_DATA-1:0] rt_data;

    id_regfile_bypass #(
        .NB_DATA (NB_DATA),
        .NB_REG  (NB_REG),
        .N_REGS  (N_REGS)
    ) u_regfile (
        .clk       (i_clk),
        .srst      (i_reset),
        .wr_en     (i_wb_write),
        .wr_addr   (i_wb_addr),
        .wr_data   (i_wb_data),
        .rd_addr_a (rs),
        .rd_addr_b (rt),
        .rd_data_a (rs_data),
        .rd_data_b (rt_data)
    );

    // ---------------- ID/EX register ----------------
    logic               valid_reg;
    logic [NB_DATA-1:0] pc_reg;
    logic [NB_DATA-1:0] data_1_reg;
    logic [NB_DATA-1:0] data_2_reg;
    logic [NB_DATA-1:0] imm_reg;
    logic [NB_REG-1:0]  rs_reg;
    logic [NB_REG-1:0]  rt_reg;
    logic [NB_REG-1:0]  rd_reg;
    logic [5:0]         opcode_reg;
    logic [5:0]         funct_reg;

    // ---------------- load-use hazard ----------------
    // A load in EX cannot forward its result to the instruction in ID;
    // hold IF/ID one cycle. A flush wins because the dependent
    // instruction is being discarded anyway.
    logic stall;

    assign stall = i_valid && valid_reg && is_load(opcode_reg) &&
                   (rt_reg != '0) &&
                   ((rt_reg == rs) || ((rt_reg == rt) && is_rt_consumer(opcode))) &&
                   !i_flush;

    assign o_stall = stall;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush || stall) begin
            // Reset, squash and stall all leave a clean bubble behind
            valid_reg  <= 1'b0;
            pc_reg     <= '0;
            data_1_reg <= '0;
            data_2_reg <= '0;
            imm_reg    <= '0;
            rs_reg     <= '0;
            rt_reg     <= '0;
            rd_reg     <= '0;
            opcode_reg <= '0;
            funct_reg  <= '0;
        end else begin
            valid_reg  <= i_valid;
            pc_reg     <= i_pc;
            data_1_reg <= rs_data;
            data_2_reg <= rt_data;
            imm_reg    <= imm_ext;
            rs_reg     <= rs;
            rt_reg     <= rt;
            rd_reg     <= rd;
            opcode_reg <= opcode;
            funct_reg  <= funct;
        end
    end

    assign o_valid  = valid_reg;
    assign o_pc     = pc_reg;
    assign o_data_1 = data_1_reg;
    assign o_data_2 = data_2_reg;
    assign o_imm    = imm_reg;
    assign o_rs     = rs_reg;
    assign o_rt     = rt_reg;
    assign o_rd     = rd_reg;
    assign o_opcode = opcode_reg;
    assign o_funct  = funct_reg;

endmodule

// File: tb/tb_id_pipeline.sv
// Self-checking bench for id_pipeline: per-scenario tasks, scoreboard of
// expected ID/EX entries, directed constant checks on top.
module tb_id_pipeline;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_valid;
    logic [31:0] i_pc;
    logic [31:0] i_instruction;
    logic        i_flush;
    logic        i_wb_write;
    logic [4:0]  i_wb_addr;
    logic [31:0] i_wb_data;
    logic        o_stall;
    logic        o_valid;
    logic [31:0] o_pc;
    logic [31:0] o_data_1;
    logic [31:0] o_data_2;
    logic [31:0] o_imm;
    logic [4:0]  o_rs;
    logic [4:0]  o_rt;
    logic [4:0]  o_rd;
    logic [5:0]  o_opcode;
    logic [5:0]  o_funct;

    id_pipeline dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_valid       (i_valid),
        .i_pc          (i_pc),
        .i_instruction (i_instruction),
        .i_flush       (i_flush),
        .i_wb_write    (i_wb_write),
        .i_wb_addr     (i_wb_addr),
        .i_wb_data     (i_wb_data),
        .o_stall       (o_stall),
        .o_valid       (o_valid),
        .o_pc          (o_pc),
        .o_data_1      (o_data_1),
        .o_data_2      (o_data_2),
        .o_imm         (o_imm),
        .o_rs          (o_rs),
        .o_rt          (o_rt),
        .o_rd          (o_rd),
        .o_opcode      (o_opcode),
        .o_funct       (o_funct)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  op;
        logic [5:0]  funct;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        m_idex;
    logic [31:0] m_regs [32];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        last_stall;

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a, input logic wbw,
                                           input logic [4:0] wba, input logic [31:0] wbd);
        if (a == 5'd0) return 32'd0;
        if (wbw && wba == a) return wbd;
        return m_regs[a];
    endfunction

    function automatic logic [31:0] m_imm(input logic [5:0] op, input logic [15:0] imm);
        if (op == 6'h0C || op == 6'h0D || op == 6'h0E) return {16'h0000, imm};
        if (op == 6'h0F) return {imm, 16'h0000};
        return {{16{imm[15]}}, imm};
    endfunction

    function automatic logic m_consumer(input logic [5:0] op);
        return op == 6'h00 || op[5:3] == 3'b101 || op == 6'h04 || op == 6'h05;
    endfunction

    // One clock: drive at negedge, check stall before the edge, push the
    // expected ID/EX entry, then pop and compare after the edge.
    task automatic step(input logic rst, input logic v, input logic [31:0] pc,
                        input logic [31:0] instr, input logic fl, input logic wbw,
                        input logic [4:0] wba, input logic [31:0] wbd);
        exp_t e;
        exp_t got;
        logic exp_stall;
        logic [4:0] rs, rt;
        @(negedge i_clk);
        i_reset = rst; i_valid = v; i_pc = pc; i_instruction = instr;
        i_flush = fl; i_wb_write = wbw; i_wb_addr = wba; i_wb_data = wbd;
        #1;
        rs = instr[25:21];
        rt = instr[20:16];
        exp_stall = v && m_idex.valid && (m_idex.op[5:3] == 3'b100) && (m_idex.rt != 5'd0) &&
                    ((m_idex.rt == rs) || ((m_idex.rt == rt) && m_consumer(instr[31:26]))) && !fl;
        last_stall = o_stall;
        n_checks++;
        if (o_stall !== exp_stall) begin
            n_fail++;
            $display("FAIL stall pc=%h: got %b expected %b", pc, o_stall, exp_stall);
        end
        e = '{valid: 1'b0, pc: 32'd0, d1: 32'd0, d2: 32'd0, imm: 32'd0,
              rs: 5'd0, rt: 5'd0, rd: 5'd0, op: 6'd0, funct: 6'd0};
        if (!rst && !fl && !exp_stall) begin
            e.valid = v;
            e.pc    = pc;
            e.d1    = m_read(rs, wbw, wba, wbd);
            e.d2    = m_read(rt, wbw, wba, wbd);
            e.imm   = m_imm(instr[31:26], instr[15:0]);
            e.rs    = rs;
            e.rt    = rt;
            e.rd    = instr[15:11];
            e.op    = instr[31:26];
            e.funct = instr[5:0];
        end
        sb_q.push_back(e);
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        end else if (wbw && wba != 5'd0) begin
            m_regs[wba] = wbd;
        end
        @(posedge i_clk);
        #1;
        if (sb_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL scoreboard: queue empty, expected an entry");
        end else begin
            got = sb_q.pop_front();
            n_checks++;
            if (o_valid !== got.valid) begin
                n_fail++;
                $display("FAIL valid pc=%h: got %b expected %b", pc, o_valid, got.valid);
            end
            n_checks++;
            if (o_pc !== got.pc) begin
                n_fail++;
                $display("FAIL pc: got %h expected %h", o_pc, got.pc);
            end
            n_checks++;
            if (o_data_1 !== got.d1 || o_data_2 !== got.d2) begin
                n_fail++;
                $display("FAIL data pc=%h: got %h/%h expected %h/%h", pc, o_data_1, o_data_2, got.d1, got.d2);
            end
            n_checks++;
            if (o_imm !== got.imm) begin
                n_fail++;
                $display("FAIL imm pc=%h: got %h expected %h", pc, o_imm, got.imm);
            end
            n_checks++;
            if ({o_rs, o_rt, o_rd, o_opcode, o_funct} !== {got.rs, got.rt, got.rd, got.op, got.funct}) begin
                n_fail++;
                $display("FAIL fields pc=%h: got %h/%h/%h/%h/%h expected %h/%h/%h/%h/%h", pc,
                         o_rs, o_rt, o_rd, o_opcode, o_funct, got.rs, got.rt, got.rd, got.op, got.funct);
            end
            m_idex = got;
        end
        $display("cycle rst=%b v=%b pc=%h instr=%h flush=%b wb=%b/%0d/%h -> stall=%b valid=%b",
                 rst, v, pc, instr, fl, wbw, wba, wbd, last_stall, o_valid);
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    localparam logic [31:0] ADD_3   = 32'h0062_2020;
    logic [31:0] lw3, add3;

    task automatic test_reset();
        step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 5'd1, 32'h5555_5555);
        step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        check_val("reset_valid", {31'd0, o_valid}, 32'd0);
        check_val("reset_opcode", {26'd0, o_opcode}, 32'd0);
        // First cycle after reset: a load-shaped instruction must not stall
        step(1'b0, 1'b1, 32'h100, itype(6'h23, 5'd1, 5'd3, 16'd4), 1'b0, 1'b0, 5'd0, 32'd0);
        check_val("post_reset_stall", {31'd0, last_stall}, 32'd0);
        check_val("reset_wb_ignored", o_data_1, 32'd0);
        step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic test_bypass();
        step(1'b0, 1'b1, 32'h200, rtype(5'd5, 5'd0, 5'd1, 6'h20), 1'b0, 1'b1, 5'd5, 32'h0000_1234);
        check_val("bypass_rs5", o_data_1, 32'h0000_1234);
        step(1'b0, 1'b1, 32'h204, rtype(5'd0, 5'd5, 5'd2, 6'h20), 1'b0, 1'b0, 5'd0, 32'd0);
        check_val("stored_rt5", o_data_2, 32'h0000_1234);
        step(1'b0, 1'b1, 32'h208, rtype(5'd0, 5'd0, 5'd2, 6'h20), 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        check_val("r0_bypass_blocked", o_data_1, 32'd0);
    endtask

    task automatic test_imm();
        step(1'b0, 1'b1, 32'h300, itype(6'h08, 5'd0, 5'd1, 16'hFFFF), 1'b0, 1'b0, 5'd0, 32'd0);
        check_val("addi_sext", o_imm, 32'hFFFF_FFFF);
        step(1'b0, 1'b1, 32'h304, itype(6'h0D, 5'd0, 5'd1, 16'hFFFF), 1'b0, 1'b0, 5'd0, 32'd0);
        check_val("ori_zext", o_imm, 32'h0000_FFFF);
        step(1'b0, 1'b1, 32'h308, itype(6'h0F, 5'd0, 5'd1, 16'h8001), 1'b0, 1'b0, 5'd0, 32'd0);
        check_val("lui", o_imm, 32'h8001_0000);
        step(1'b0, 1'b1, 32'h30C, itype(6'h0C, 5'd0, 5'd1, 16'h8000), 1'b0, 1'b0, 5'd0, 32'd0);
        check_val("andi_zext", o_imm, 32'h0000_8000);
        step(1'b0, 1'b1, 32'h310, itype(6'h23, 5'd0, 5'd1, 16'h8000), 1'b0, 1'b0, 5'd0, 32'd0);
        check_val("lw_sext", o_imm, 32'hFFFF_8000);
        step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic test_load_use();
        step(1'b0, 1'b1, 32'h400, lw3, 1'b0, 1'b0, 5'd0, 32'd0);
        step(1'b0, 1'b1, 32'h404, add3, 1'b0, 1'b0, 5'd0, 32'd0);
        check_val("lu_stall", {31'd0, last_stall}, 32'd1);
        check_val("lu_bubble", {31'd0, o_valid}, 32'd0);
        step(1'b0, 1'b1, 32'h404, add3, 1'b0, 1'b0, 5'd0, 32'd0);
        check_val("lu_stall_once", {31'd0, last_stall}, 32'd0);
        check_val("lu_add_captured", {27'd0, o_rs}, 32'd3);
    endtask

    task automatic test_store_and_zero();
        step(1'b0, 1'b1, 32'h500, lw3, 1'b0, 1'b0, 5'd0, 32'd0);
        step(1'b0, 1'b1, 32'h504, itype(6'h2B, 5'd0, 5'd3, 16'd8), 1'b0, 1'b0, 5'd0, 32'd0);
        check_val("sw_rt_stall", {31'd0, last_stall}, 32'd1);
        step(1'b0, 1'b1, 32'h508, itype(6'h23, 5'd1, 5'd0, 16'd0), 1'b0, 1'b0, 5'd0, 32'd0);
        step(1'b0, 1'b1, 32'h50C, rtype(5'd0, 5'd2, 5'd4, 6'h20), 1'b0, 1'b0, 5'd0, 32'd0);
        check_val("lw_r0_no_stall", {31'd0, last_stall}, 32'd0);
        // ADDI only reads rs, so a match on its rt field is not a hazard
        step(1'b0, 1'b1, 32'h510, lw3, 1'b0, 1'b0, 5'd0, 32'd0);
        step(1'b0, 1'b1, 32'h514, itype(6'h08, 5'd1, 5'd3, 16'd1), 1'b0, 1'b0, 5'd0, 32'd0);
        check_val("addi_rt_no_stall", {31'd0, last_stall}, 32'd0);
    endtask

    task automatic test_flush();
        step(1'b0, 1'b1, 32'h600, lw3, 1'b0, 1'b0, 5'd0, 32'd0);
        step(1'b0, 1'b1, 32'h604, add3, 1'b1, 1'b0, 5'd0, 32'd0);
        check_val("flush_no_stall", {31'd0, last_stall}, 32'd0);
        check_val("flush_bubble", {31'd0, o_valid}, 32'd0);
    endtask

    task automatic test_reset_midstream();
        step(1'b0, 1'b0, 32'h700, 32'd0, 1'b0, 1'b1, 5'd7, 32'h0000_DEAD);
        step(1'b0, 1'b1, 32'h704, rtype(5'd7, 5'd7, 5'd1, 6'h20), 1'b0, 1'b0, 5'd0, 32'd0);
        check_val("r7_written", o_data_1, 32'h0000_DEAD);
        step(1'b1, 1'b1, 32'h708, rtype(5'd7, 5'd7, 5'd1, 6'h20), 1'b0, 1'b0, 5'd0, 32'd0);
        check_val("mid_reset_valid", {31'd0, o_valid}, 32'd0);
        step(1'b0, 1'b1, 32'h70C, rtype(5'd7, 5'd7, 5'd1, 6'h20), 1'b0, 1'b0, 5'd0, 32'd0);
        check_val("r7_cleared", o_data_1, 32'd0);
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops [9];
        logic [31:0] instr;
        ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2B; ops[3] = 6'h04; ops[4] = 6'h08;
        ops[5] = 6'h0C; ops[6] = 6'h0F; ops[7] = 6'h05; ops[8] = 6'h20;
        for (int n = 0; n < 300; n++) begin
            instr = {ops[$urandom_range(0, 8)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     16'($urandom())};
            step(1'b0, 1'($urandom_range(0, 7) != 0), 32'($urandom()), instr,
                 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 31)), 32'($urandom()));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset = 1'b1; i_valid = 1'b0; i_pc = '0; i_instruction = '0; i_flush = 1'b0;
        i_wb_write = 1'b0; i_wb_addr = '0; i_wb_data = '0;
        m_idex = '{valid: 1'b0, pc: 32'd0, d1: 32'd0, d2: 32'd0, imm: 32'd0,
                   rs: 5'd0, rt: 5'd0, rd: 5'd0, op: 6'd0, funct: 6'd0};
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        lw3  = itype(6'h23, 5'd1, 5'd3, 16'd4);
        add3 = rtype(5'd3, 5'd2, 5'd4, 6'h20);
        test_reset();
        test_bypass();
        test_imm();
        test_load_use();
        test_store_and_zero();
        test_flush();
        test_reset_midstream();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
